hit_recoil_ctrl: RTL
====================

# hit_recoil_ctrl

Per-player recoil controller: the receiving end of a punch. When the collision logic reports that the opponent's punch landed, this block drives a decaying rightward knockback on the victim's X motion, clamped to the right wall. It then holds the player stunned for a fixed number of frames and tracks remaining health. It sits beside the punch controller and feeds the same X-motion summing path into the sprite position register.

## Interface
Parameters:
- BOUND_X_MAX, 638, rightmost legal pixel column.
- SPRITE_W, 125, sprite width in pixels; right edge = Xpos + SPRITE_W.
- STUN_FRAMES, 16, frames held stunned after recoil (1..255).
- HEALTH_INIT, 10, starting health (1..15).

Ports:
- clk  in  1  system clock; the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame; FSM advances only on ticks.
- hit  in  1  opponent punch landed (pulse, any cycle).
- blocking  in  1  player is blocking/crouching.
- Xpos  in  10  victim's current left X position, unsigned.
- X_Motion  out  10  signed recoil motion, pixels per frame, registered.
- stunned  out  1  high in any non-IDLE state; punch controller must ignore Punch while high.
- health  out  4  remaining health.
- ko  out  1  health reached 0; sticky until reset.

## Operation
- Reset values: state IDLE, X_Motion 0, stunned 0, health HEALTH_INIT, ko 0, hit_pend 0, blk 0, stun counter 0.
- hit_pend is set on any cycle with hit=1. It is cleared on every frame_tick. A hit coinciding with a tick counts for that tick.
- wall_dist = BOUND_X_MAX − (Xpos + SPRITE_W), computed 12-bit signed. A negative value is treated as 0.
- States: IDLE, R1, R2, R3, R4, R5, STUN, KO. All transitions occur only on frame_tick.
- IDLE:
  - On a tick with (hit_pend | hit), go to R1, decrement health by 1 (saturating at 0), and latch blk.
  - If the decremented health is 0, go to KO instead.
- Recoil profile (unblocked): R1=6, R2=5, R3=4, R4=3, R5=2.
- On entering Rn, X_Motion = profile(Rn).
  - If wall_dist < profile, X_Motion = wall_dist, and the state goes straight to STUN on the next tick.
  - Otherwise R1→R2→…→R5→STUN.
- STUN:
  - X_Motion = 0.
  - The counter loads STUN_FRAMES on entry and decrements per tick.
  - Go to IDLE on the tick at which the counter is 1.
- KO: X_Motion 0, stunned 1, ko 1; no exit except reset.
- Hits during R1..R5 or STUN are discarded: no health change and no restart (invulnerability window). hit_pend is still cleared by the tick.
- Reset asserted mid-recoil immediately returns all outputs to reset values. There is no stale motion after deassertion.

## Timing
- All outputs are registered. They change only in the clk edge where frame_tick=1, except for asynchronous reset.
- Latency: hit in any cycle up to and including tick k → X_Motion=6 and stunned=1 from the edge of tick k, held until tick k+1.
- Full unblocked recoil occupies 5 ticks of motion, then STUN_FRAMES ticks with stunned=1, then IDLE. Total stunned = 5 + STUN_FRAMES frames.
- The wall clamp uses the Xpos sampled in the tick cycle.
- The motion sequence from the wall case ends with a value in 0..profile−1 followed by STUN.

## Configuration
- RECOIL_BLOCK_EN defined:
  - blocking sampled at hit acceptance sets blk.
  - With blk, the profile is halved with floor: 3,2,2,1,1.
  - With blk, health is not decremented, so KO cannot occur from a blocked hit.
  - STUN_FRAMES is unchanged.
- RECOIL_BLOCK_EN undefined: blocking is ignored, blk is tied to 0, and the full profile and decrement always apply.

## Test plan
- Xpos=100, single hit pulse 3 cycles before a tick, STUN_FRAMES=16 → X_Motion 6,5,4,3,2 over 5 ticks, then 0 with stunned=1 for 16 ticks, then stunned=0; health 10→9.
- Xpos=505 (wall_dist 8) → X_Motion 6, then 2 (clamped, dist 2 after move), then STUN; it never exceeds the remaining distance.
- Second hit during R3 and another during STUN → profile continues unchanged; health decrements only once.
- HEALTH_INIT=1, one hit → ko=1, stunned=1, X_Motion=0, and ko remains set for 100 ticks regardless of hits; Reset_n low → health=1, ko=0.
- Reset_n pulsed low between ticks while in R2 → X_Motion=0 and stunned=0 immediately; the next hit restarts at R1=6.
- RECOIL_BLOCK_EN defined, blocking=1 at hit → X_Motion 3,2,2,1,1, health unchanged; with the macro undefined, the same stimulus gives 6,5,4,3,2 and health−1.

Source files
------------

// File: rtl/hit_recoil_ctrl_if.sv
// hit_recoil_ctrl_if
// Bundles the per-player recoil controller signals so the controller and
// whatever drives it (collision logic, punch controller, bench) share one
// connection point.
//
// Signals
//   frame_tick  one-cycle pulse per video frame
//   hit         opponent punch landed (pulse, any cycle)
//   blocking    player is blocking/crouching
//   Xpos        victim's current left X position, unsigned
//   X_Motion    signed recoil motion in pixels per frame
//   stunned     high in every non-IDLE state
//   health      remaining health
//   ko          health reached zero; sticky until reset
//   state_dbg   current FSM state encoding, for observation only
//
// Modports
//   master  drives frame_tick/hit/blocking/Xpos, observes the outputs
//   slave   the recoil controller itself
interface hit_recoil_ctrl_if;
  logic              frame_tick;
  logic              hit;
  logic              blocking;
  logic [9:0]        Xpos;
  logic signed [9:0] X_Motion;
  logic              stunned;
  logic [3:0]        health;
  logic              ko;
  logic [2:0]        state_dbg;

  modport master (
    output frame_tick, hit, blocking, Xpos,
    input  X_Motion, stunned, health, ko, state_dbg
  );

  modport slave (
    input  frame_tick, hit, blocking, Xpos,
    output X_Motion, stunned, health, ko, state_dbg
  );
endinterface

// File: rtl/hit_recoil_ctrl.sv
// hit_recoil_ctrl
// Receiving end of a punch. A landed hit starts a five-frame decaying
// rightward knockback (clamped so the sprite never crosses the right wall),
// followed by a fixed stun period, while health counts down to a sticky KO.
//
// Ports
//   clk      system clock, the only clock
//   Reset_n  asynchronous active-low reset
//   bus      hit_recoil_ctrl_if.slave (frame_tick, hit, blocking, Xpos in;
//            X_Motion, stunned, health, ko, state_dbg out)
//
// Optional feature: define RECOIL_BLOCK_EN to make a hit taken while
// blocking halve the knockback profile and cost no health.
//
// Signalling: there is no valid/ready handshake here. hit is a pulse that may
// arrive on any cycle and is remembered until the next frame_tick; frame_tick
// is a one-cycle pulse and is the only cycle in which any registered output
// may change (apart from asynchronous reset). No back-pressure exists: a hit
// that arrives while recoiling or stunned is simply dropped.
module hit_recoil_ctrl #(
  parameter int BOUND_X_MAX = 638,
  parameter int SPRITE_W    = 125,
  parameter int STUN_FRAMES = 16,
  parameter int HEALTH_INIT = 10
) (
  input logic              clk,
  input logic              Reset_n,
  hit_recoil_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R1   = 3'd1,
    R2   = 3'd2,
    R3   = 3'd3,
    R4   = 3'd4,
    R5   = 3'd5,
    STUN = 3'd6,
    KO   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic signed [9:0] x_motion_q, x_motion_d;
  logic              stunned_q, stunned_d;
  logic [3:0]        health_q, health_d;
  logic              ko_q, ko_d;
  logic              hit_pend_q, hit_pend_d;
  logic              blk_q, blk_d;
  // Set when the current recoil step was cut short by the wall; the next
  // tick then goes straight to STUN instead of the next profile step.
  logic              clamped_q, clamped_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              blk_in;
  logic              accept;
  logic [3:0]        health_dec;
  logic              enter_r;
  logic              enter_stun;
  logic [3:0]        prof;
  logic [11:0]       right_edge;
  logic [11:0]       wall_raw;
  logic [11:0]       wall_sat;

`ifdef RECOIL_BLOCK_EN
  assign blk_in = bus.blocking;
`else
  // Blocking has no effect in this build; the AND keeps the input referenced.
  assign blk_in = 1'b0 & bus.blocking;
`endif

  // Distance to the right wall, 12-bit two's complement; a sprite already
  // past the wall yields a negative result, which counts as no room at all.
  assign right_edge = {2'b00, bus.Xpos} + 12'(SPRITE_W);
  assign wall_raw   = 12'(BOUND_X_MAX) - right_edge;
  assign wall_sat   = wall_raw[11] ? 12'd0 : wall_raw;

  function automatic logic [3:0] base_profile(input state_t s);
    case (s)
      R1:      base_profile = 4'd6;
      R2:      base_profile = 4'd5;
      R3:      base_profile = 4'd4;
      R4:      base_profile = 4'd3;
      R5:      base_profile = 4'd2;
      default: base_profile = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      x_motion_q <= '0;
      stunned_q  <= 1'b0;
      health_q   <= 4'(HEALTH_INIT);
      ko_q       <= 1'b0;
      hit_pend_q <= 1'b0;
      blk_q      <= 1'b0;
      clamped_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_motion_q <= x_motion_d;
      stunned_q  <= stunned_d;
      health_q   <= health_d;
      ko_q       <= ko_d;
      hit_pend_q <= hit_pend_d;
      blk_q      <= blk_d;
      clamped_q  <= clamped_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_motion_d = x_motion_q;
    stunned_d  = stunned_q;
    health_d   = health_q;
    ko_d       = ko_q;
    blk_d      = blk_q;
    clamped_d  = clamped_q;
    cnt_d      = cnt_q;
    enter_r    = 1'b0;
    enter_stun = 1'b0;
    prof       = 4'd0;

    // A hit in the tick cycle itself counts for that tick.
    accept      = hit_pend_q | bus.hit;
    hit_pend_d  = bus.frame_tick ? 1'b0 : accept;
    health_dec  = (health_q == 4'd0) ? 4'd0 : (health_q - 4'd1);

    if (bus.frame_tick) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            blk_d = blk_in;
            if (!blk_in) begin
              health_d = health_dec;
            end
            if (!blk_in && (health_dec == 4'd0)) begin
              state_d    = KO;
              ko_d       = 1'b1;
              x_motion_d = '0;
            end else begin
              state_d = R1;
              enter_r = 1'b1;
            end
          end
        end
        R1: begin
          if (clamped_q) enter_stun = 1'b1;
          else begin state_d = R2; enter_r = 1'b1; end
        end
        R2: begin
          if (clamped_q) enter_stun = 1'b1;
          else begin state_d = R3; enter_r = 1'b1; end
        end
        R3: begin
          if (clamped_q) enter_stun = 1'b1;
          else begin state_d = R4; enter_r = 1'b1; end
        end
        R4: begin
          if (clamped_q) enter_stun = 1'b1;
          else begin state_d = R5; enter_r = 1'b1; end
        end
        R5: begin
          enter_stun = 1'b1;
        end
        STUN: begin
          // Leave on the tick that sees the counter at 1; <= also rescues a
          // zero count so the FSM can never park in STUN.
          if (cnt_q <= 8'd1) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        KO: begin
          x_motion_d = '0;
          ko_d       = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (enter_stun) begin
        state_d    = STUN;
        x_motion_d = '0;
        cnt_d      = 8'(STUN_FRAMES);
        clamped_d  = 1'b0;
      end

      if (enter_r) begin
        // A blocked hit uses half the profile, rounded down.
        prof = blk_d ? (base_profile(state_d) >> 1) : base_profile(state_d);
        if (wall_sat < {8'd0, prof}) begin
          x_motion_d = 10'(wall_sat);
          clamped_d  = 1'b1;
        end else begin
          x_motion_d = 10'(prof);
          clamped_d  = 1'b0;
        end
      end

      stunned_d = (state_d != IDLE);
    end
  end

  assign bus.X_Motion  = x_motion_q;
  assign bus.stunned   = stunned_q;
  assign bus.health    = health_q;
  assign bus.ko        = ko_q;
  assign bus.state_dbg = state_q;

endmodule
